regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NUM_REQ writeback sources (ALU, LSU, MDU).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: data and index
// widths, register count, and the fixed requester slot assignment.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Requester slots on the writeback arbiter
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans req starting at ptr, wrapping modulo NUM_REQ,
// and grants the first asserted request. Purely combinational.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Pick the first valid requester at or after the pointer
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Round-robin grants across NUM_REQ sources, one registered output stage that
// drives the regfile isWrite/rd/writeData inputs directly.
// Optional feature macro: WB_SCOREBOARD_EN adds a pending-write busy register
// and a combinational hazard output for the issue stage.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]      req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rf_isWrite,
    output logic [REG_ADDR_W-1:0]        rf_rd,
    output logic [XLEN-1:0]              rf_writeData,
    input  logic                         alloc_valid,
    input  logic [REG_ADDR_W-1:0]        alloc_rd,
    input  logic [REG_ADDR_W-1:0]        chk_rs1,
    input  logic [REG_ADDR_W-1:0]        chk_rs2,
    output logic                         hazard
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The write port never stalls, so the grant is the ready
    assign req_ready = gnt;
    assign gnt_any   = |gnt;

    // Select the winner's destination and data from the packed request buses
    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                win_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Advance the round-robin pointer past the winner; hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of block order.
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output stage: capture the winner, write only for a nonzero destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_isWrite   <= 1'b0;
            rf_rd        <= '0;
            rf_writeData <= '0;
        end else if (gnt_any) begin
            rf_isWrite   <= (win_rd != '0);
            rf_rd        <= win_rd;
            rf_writeData <= win_data;
        end else begin
            rf_isWrite   <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Clear on retirement first, then set on allocation so a new producer wins
    always_comb begin
        busy_nxt = busy;
        if (rf_isWrite) begin
            busy_nxt[rf_rd] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != '0)) begin
            busy_nxt[alloc_rd] = 1'b1;
        end
    end

    // Pending-write scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: busy is control state read every cycle, so unlike a data array it must come out of reset cleared.
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // A register being written this cycle is bypassed by the regfile, so it is not a hazard
    assign hazard = ((chk_rs1 != '0) && busy[chk_rs1] && !(rf_isWrite && (rf_rd == chk_rs1)))
                 || ((chk_rs2 != '0) && busy[chk_rs2] && !(rf_isWrite && (rf_rd == chk_rs2)));
`else
    logic unused_sb;

    assign unused_sb = &{1'b0, alloc_valid, alloc_rd, chk_rs1, chk_rs2};
    assign hazard    = 1'b0;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled a further unit later.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NUM_REQ = 3;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
    logic [NUM_REQ*XLEN-1:0]       req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rf_isWrite;
    logic [REG_ADDR_W-1:0]         rf_rd;
    logic [XLEN-1:0]               rf_writeData;
    logic                          alloc_valid;
    logic [REG_ADDR_W-1:0]         alloc_rd;
    logic [REG_ADDR_W-1:0]         chk_rs1;
    logic [REG_ADDR_W-1:0]         chk_rs2;
    logic                          hazard;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_isWrite   (rf_isWrite),
        .rf_rd        (rf_rd),
        .rf_writeData (rf_writeData),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .hazard       (hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Move to 1 unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [4:0] rd0, input logic [31:0] d0,
                           input logic [4:0] rd1, input logic [31:0] d1,
                           input logic [4:0] rd2, input logic [31:0] d2);
        req_valid = v;
        req_rd    = {rd2, rd1, rd0};
        req_data  = {d2, d1, d0};
    endtask

    logic [2:0]  exp_gnt [6];
    logic [4:0]  exp_rd  [6];
    logic [31:0] exp_dat [6];

    initial begin
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        chk_rs1     = '0;
        chk_rs2     = '0;
        set_req(3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33);

        // 1. Reset held with all requesters valid
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check($sformatf("reset_iswrite_%0d", i), 32'(rf_isWrite), 32'd0);
            check($sformatf("reset_rd_%0d", i), 32'(rf_rd), 32'd0);
        end
        check("reset_wdata", rf_writeData, 32'd0);
        check("reset_hazard", 32'(hazard), 32'd0);

        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_iswrite", 32'(rf_isWrite), 32'd0);

        // 2. Single ALU request, rd=5
        set_req(3'b001, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("alu_ready", 32'(req_ready), 32'b001);
        tick();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("alu_iswrite", 32'(rf_isWrite), 32'd1);
        check("alu_rd", 32'(rf_rd), 32'd5);
        check("alu_wdata", rf_writeData, 32'hDEADBEEF);
        check("alu_noready_after", 32'(req_ready), 32'd0);
        tick();
        #1;
        check("alu_iswrite_drop", 32'(rf_isWrite), 32'd0);
        check("alu_rd_hold", 32'(rf_rd), 32'd5);
        check("alu_wdata_hold", rf_writeData, 32'hDEADBEEF);

        // 4. LSU with rd=0 (pointer is 1 after the ALU grant)
        set_req(3'b010, 5'd0, 32'h0, 5'd0, 32'h1234, 5'd0, 32'h0);
        #1;
        check("lsu_rd0_ready", 32'(req_ready), 32'b010);
        tick();
        set_req(3'b111, 5'd10, 32'hA0, 5'd11, 32'hB1, 5'd12, 32'hC2);
        #1;
        check("lsu_rd0_iswrite", 32'(rf_isWrite), 32'd0);
        check("lsu_rd0_rd", 32'(rf_rd), 32'd0);
        check("lsu_rd0_wdata", rf_writeData, 32'h1234);
        check("ptr_after_lsu", 32'(req_ready), 32'b100);

        // Reset mid-operation: MDU write in the output stage is lost at once
        tick();
        check("mdu_iswrite_pre_rst", 32'(rf_isWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_iswrite", 32'(rf_isWrite), 32'd0);
        check("midrst_rd", 32'(rf_rd), 32'd0);
        tick();
        rst_n = 1'b1;

        // 3. All three held from ptr=0 for six cycles
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_rd  = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11, 5'd12};
        exp_dat = '{32'hA0, 32'hB1, 32'hC2, 32'hA0, 32'hB1, 32'hC2};
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_gnt_%0d", k), 32'(req_ready), 32'(exp_gnt[k]));
            tick();
            #1;
            check($sformatf("rr_iswrite_%0d", k), 32'(rf_isWrite), 32'd1);
            check($sformatf("rr_rd_%0d", k), 32'(rf_rd), 32'(exp_rd[k]));
            check($sformatf("rr_wdata_%0d", k), rf_writeData, exp_dat[k]);
        end
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        check("rr_idle_iswrite", 32'(rf_isWrite), 32'd0);

`ifdef WB_SCOREBOARD_EN
        // 5. Allocate x7, then MDU retires x7
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk_rs1     = 5'd7;
        #1;
        check("sb_hazard_rs1_7", 32'(hazard), 32'd1);
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd7;
        #1;
        check("sb_hazard_rs2_7", 32'(hazard), 32'd1);
        chk_rs2 = 5'd8;
        #1;
        check("sb_nohazard_8", 32'(hazard), 32'd0);
        chk_rs1 = 5'd7;
        set_req(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h77);
        #1;
        check("sb_mdu_ready", 32'(req_ready), 32'b100);
        tick();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("sb_mdu_iswrite", 32'(rf_isWrite), 32'd1);
        check("sb_bypass_nohazard", 32'(hazard), 32'd0);
        tick();
        #1;
        check("sb_busy7_cleared", 32'(hazard), 32'd0);

        // 6. Allocate x9 in the same cycle x9 retires: set wins
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd9;
        set_req(3'b001, 5'd9, 32'h99, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        #1;
        check("sb_x9_iswrite", 32'(rf_isWrite), 32'd1);
        check("sb_x9_rd", 32'(rf_rd), 32'd9);
        tick();
        alloc_valid = 1'b0;
        #1;
        check("sb_x9_set_wins", 32'(hazard), 32'd1);
`else
        // Without the scoreboard, allocations are ignored and hazard stays low
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk_rs1     = 5'd7;
        chk_rs2     = 5'd7;
        #1;
        check("nosb_hazard", 32'(hazard), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
